refclk_monitor: RTL

//  Frequency/presence checker for the SerDes reference clock taken from the EXTREFB buffer output
//  (REFCLKO, divided so it is below clk/2). Samples refclk in the fabric clock domain and counts its

---
 rtl/refclk_mon_pkg.sv | 17 +
 rtl/refclk_edge_sync.sv | 31 +++
 rtl/refclk_monitor.sv | 136 +++++++++++++
 3 files changed

// File: rtl/refclk_mon_pkg.sv
// rtl/refclk_mon_pkg.sv - lock state type and good-range check shared by the refclk monitor
`timescale 1ns/1ps
package refclk_mon_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKING  = 2'd1,
    LOCKED   = 2'd2
  } mon_state_t;

  function automatic logic in_range(input int unsigned count,
                                    input int unsigned lo,
                                    input int unsigned hi);
    return (count >= lo) && (count <= hi);
  endfunction

endpackage

// File: rtl/refclk_edge_sync.sv
// rtl/refclk_edge_sync.sv - two-flop synchroniser with rising-edge detect for an async clock input
`timescale 1ns/1ps
module refclk_edge_sync
  import refclk_mon_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic edge_pulse
);

  logic s1;
  logic s2;
  logic s3;

  // s1/s2 resolve metastability; s3 is the history flop for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_pulse = s2 & ~s3;

endmodule

// File: rtl/refclk_monitor.sv
// rtl/refclk_monitor.sv - refclk presence/frequency monitor; REFCLK_MON_STICKY_EN adds a latched loss flag
`timescale 1ns/1ps
module refclk_monitor
  import refclk_mon_pkg::*;
#(
  parameter  int unsigned WINDOW       = 1024,
  parameter  int unsigned EXP_MIN      = 240,
  parameter  int unsigned EXP_MAX      = 272,
  parameter  int unsigned LOCK_WINDOWS = 4,
  localparam int unsigned CNT_W        = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             refclk,
  output logic [CNT_W-1:0] freq_count,
  output logic             count_valid,
  output logic             refclk_ok,
  output logic             refclk_lost
`ifdef REFCLK_MON_STICKY_EN
  ,
  input  logic             sticky_clr,
  output logic             lost_sticky
`endif
);

  localparam int unsigned WIN_W  = $clog2(WINDOW);
  localparam int unsigned GOOD_W = $clog2(LOCK_WINDOWS + 1);

  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic              edge_pulse;
  logic [WIN_W-1:0]  win_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic [CNT_W-1:0]  edge_next;
  logic              win_end;
  logic              good;
  logic [GOOD_W-1:0] good_cnt;
  mon_state_t        state;

  refclk_edge_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .async_in  (refclk),
    .edge_pulse(edge_pulse)
  );

  assign win_end = (win_cnt == WIN_LAST);

  // Saturate rather than wrap so an over-fast refclk can never alias into the good range
  assign edge_next = (edge_cnt == CNT_MAX) ? edge_cnt : edge_cnt + CNT_W'(edge_pulse);

  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt     <= '0;
      edge_cnt    <= '0;
      freq_count  <= '0;
      count_valid <= 1'b0;
    end else if (!en) begin
      win_cnt     <= '0;
      edge_cnt    <= '0;
      count_valid <= 1'b0;
    end else begin
      count_valid <= win_end;
      if (win_end) begin
        win_cnt    <= '0;
        edge_cnt   <= '0;
        freq_count <= edge_next;
      end else begin
        win_cnt  <= win_cnt + 1'b1;
        edge_cnt <= edge_next;
      end
    end
  end

  assign good = in_range(32'(freq_count), EXP_MIN, EXP_MAX);

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      state       <= UNLOCKED;
      good_cnt    <= '0;
      refclk_lost <= 1'b0;
    end else begin
      refclk_lost <= 1'b0;
      if (count_valid) begin
        case (state)
          UNLOCKED: begin
            if (good) begin
              state    <= (LOCK_WINDOWS == 1) ? LOCKED : LOCKING;
              good_cnt <= GOOD_W'(1);
            end
          end
          LOCKING: begin
            if (good) begin
              good_cnt <= good_cnt + 1'b1;
              if (32'(good_cnt) + 32'd1 >= LOCK_WINDOWS) begin
                state <= LOCKED;
              end
            end else begin
              state    <= UNLOCKED;
              good_cnt <= '0;
            end
          end
          LOCKED: begin
            if (!good) begin
              state       <= UNLOCKED;
              good_cnt    <= '0;
              refclk_lost <= 1'b1;
            end
          end
          default: begin
            state    <= UNLOCKED;
            good_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign refclk_ok = (state == LOCKED);

`ifdef REFCLK_MON_STICKY_EN
  // A loss in the same cycle as a clear must not be dropped, so set has priority
  always_ff @(posedge clk) begin
    if (rst) begin
      lost_sticky <= 1'b0;
    end else if (refclk_lost) begin
      lost_sticky <= 1'b1;
    end else if (sticky_clr) begin
      lost_sticky <= 1'b0;
    end
  end
`endif

endmodule
